onchip_mem_rr_arbiter: RTL

- Shares the single-port 32-bit on-chip RAM slave (14-bit word address, 10240 words, byte enables, read data valid one cycle after address) between two Avalon-MM masters, m0 and m1.
- Round-robin arbitration, one access granted per cycle.
- Pipelined read-data return with per-master readdatavalid.
- Out-of-range addresses are blocked before reaching the RAM.

---
 rtl/onchip_mem_rr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/onchip_mem_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// One access is granted per cycle. Read data returns one cycle after acceptance,
// tagged back to its owner. Accesses to addresses at or above DEPTH never reach the RAM.
module onchip_mem_rr_arbiter #(
    parameter int unsigned        ADDR_W   = 14,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        DEPTH    = 10240,
    parameter logic [DATA_W-1:0]  OOR_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    // master 0
    input  logic [ADDR_W-1:0]     m0_address_i,
    input  logic [DATA_W/8-1:0]   m0_byteenable_i,
    input  logic                  m0_read_i,
    input  logic                  m0_write_i,
    input  logic [DATA_W-1:0]     m0_writedata_i,
    output logic                  m0_waitrequest_o,
    output logic [DATA_W-1:0]     m0_readdata_o,
    output logic                  m0_readdatavalid_o,
    // master 1
    input  logic [ADDR_W-1:0]     m1_address_i,
    input  logic [DATA_W/8-1:0]   m1_byteenable_i,
    input  logic                  m1_read_i,
    input  logic                  m1_write_i,
    input  logic [DATA_W-1:0]     m1_writedata_i,
    output logic                  m1_waitrequest_o,
    output logic [DATA_W-1:0]     m1_readdata_o,
    output logic                  m1_readdatavalid_o,
    // RAM slave
    output logic [ADDR_W-1:0]     mem_address_o,
    output logic [DATA_W/8-1:0]   mem_byteenable_o,
    output logic                  mem_chipselect_o,
    output logic                  mem_write_o,
    output logic [DATA_W-1:0]     mem_writedata_o,
    output logic                  mem_clken_o,
    input  logic [DATA_W-1:0]     mem_readdata_i
);

    localparam int unsigned   BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              rd;
        logic              wr;
    } mreq_t;

    mreq_t m0_c, m1_c, win_c;
    logic  req0_c, req1_c;
    logic  gnt0_c, gnt1_c, granted_c, in_range_c;
    logic  last_grant_q, last_grant_d;
    logic  rd_valid_q, rd_valid_d;
    logic  rd_owner_q, rd_owner_d;
    logic  rd_oor_q, rd_oor_d;
    logic [DATA_W-1:0] rd_data_c;

    // Bundle master requests into payloads
    always_comb begin
        m0_c   = '{addr: m0_address_i, be: m0_byteenable_i, wdata: m0_writedata_i,
                   rd: m0_read_i, wr: m0_write_i};
        m1_c   = '{addr: m1_address_i, be: m1_byteenable_i, wdata: m1_writedata_i,
                   rd: m1_read_i, wr: m1_write_i};
        req0_c = m0_read_i | m0_write_i;
        req1_c = m1_read_i | m1_write_i;
    end

    // Round-robin grant: on contention the master that did not win last time wins
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!reset) begin
            if (req0_c && req1_c) begin
                gnt0_c = last_grant_q;
                gnt1_c = ~last_grant_q;
            end else begin
                gnt0_c = req0_c;
                gnt1_c = req1_c;
            end
        end
        granted_c  = gnt0_c | gnt1_c;
        win_c      = gnt1_c ? m1_c : m0_c;
        in_range_c = ({1'b0, win_c.addr} < DEPTH_C);
    end

    // RAM drive and master handshakes
    always_comb begin
        m0_waitrequest_o = ~gnt0_c;
        m1_waitrequest_o = ~gnt1_c;
        mem_address_o    = granted_c ? win_c.addr  : '0;
        mem_byteenable_o = granted_c ? win_c.be    : '0;
        mem_writedata_o  = granted_c ? win_c.wdata : '0;
        mem_chipselect_o = granted_c & in_range_c;
        mem_write_o      = granted_c & in_range_c & win_c.wr;
        mem_clken_o      = ~reset;
    end

    // Next-state for arbitration history and the read-return pipeline
    always_comb begin
        last_grant_d = last_grant_q;
        if (granted_c) begin
            last_grant_d = gnt1_c;
        end
        // a simultaneous write takes precedence, so it produces no read return
        rd_valid_d = granted_c & win_c.rd & ~win_c.wr;
        rd_owner_d = gnt1_c;
        rd_oor_d   = granted_c & ~in_range_c;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_valid_q   <= rd_valid_d;
            rd_owner_q   <= rd_owner_d;
            rd_oor_q     <= rd_oor_d;
        end
    end

    // Steer returning read data to its owner; the other master sees zeros
    always_comb begin
        rd_data_c          = rd_oor_q ? OOR_DATA : mem_readdata_i;
        m0_readdatavalid_o = rd_valid_q & ~rd_owner_q;
        m1_readdatavalid_o = rd_valid_q &  rd_owner_q;
        m0_readdata_o      = m0_readdatavalid_o ? rd_data_c : '0;
        m1_readdata_o      = m1_readdatavalid_o ? rd_data_c : '0;
    end

endmodule
